// File: rtl/rs232_rx_fifo.sv
// Receive-side byte FIFO between the RS-232 receiver and the CPU I/O bus.
// Drains each received byte through the rdy/done handshake and keeps a sticky overrun flag.
module rs232_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  rx_done,
    input  logic                  rd,
    input  logic                  clr_ovr,
    output logic [7:0]            dout,
    output logic                  rdy,
    output logic                  overrun,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  pop;
    logic                  take;
    logic                  push;
    logic                  drop;

    assign rdy  = (count != '0);
    assign pop  = rd & ce & rdy;
    assign dout = rdy ? mem[rp] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full FIFO still accepts the byte when the CPU frees a slot in the same cycle.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_rdy) begin
                    take       = 1'b1;
                    state_next = S_WAIT;
                    if ((count != FULL_COUNT) || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!rx_rdy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rx_done <= 1'b0;
        end else begin
            rx_done <= take;
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr && ce) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wp] <= rx_data;
        end
    end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: directed handshake scenarios plus random traffic
// compared against a queue-based model of the buffer.
module tb_rs232_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd;
    logic       clr_ovr;
    logic [7:0] dout;
    logic       rdy;
    logic       overrun;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [$];
    bit         model_ovr;
    bit         armed;
    bit         exp_done;

    rs232_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rd      (rd),
        .clr_ovr (clr_ovr),
        .dout    (dout),
        .rdy     (rdy),
        .overrun (overrun),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic applyStimulus(input bit r, input bit rxv, input logic [7:0] d,
                                 input bit rdv, input bit cev, input bit clrv);
        bit         do_pop;
        bit         cap;
        bit         dropped;
        logic [7:0] popped;
        rst     = r;
        rx_rdy  = rxv;
        rx_data = d;
        rd      = rdv;
        ce      = cev;
        clr_ovr = clrv;
        dropped = 1'b0;
        if (r) begin
            q.delete();
            model_ovr = 1'b0;
            armed     = 1'b1;
            exp_done  = 1'b0;
        end else begin
            do_pop = rdv && cev && (q.size() > 0);
            cap    = rxv && armed;
            if (do_pop) popped = q.pop_front();
            if (cap) begin
                if (q.size() < 16) q.push_back(d);
                else dropped = 1'b1;
            end
            if (clrv && cev) model_ovr = 1'b0;
            if (dropped) model_ovr = 1'b1;
            if (cap) armed = 1'b0;
            else if (!rxv) armed = 1'b1;
            exp_done = cap;
        end
        @(posedge clk);
        #1;
        checkOutput("count", 32'(count), 32'(q.size()));
        checkOutput("rdy", 32'(rdy), 32'(q.size() != 0));
        checkOutput("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        checkOutput("overrun", 32'(overrun), 32'(model_ovr));
        checkOutput("rx_done", 32'(rx_done), 32'(exp_done));
    endtask

    task automatic sendByte(input logic [7:0] d, input bit rd_during);
        applyStimulus(1'b0, 1'b1, d, rd_during, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic popOne();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; rd = 1'b0; clr_ovr = 1'b0;
        model_ovr = 1'b0; armed = 1'b1; exp_done = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] single byte");
        sendByte(8'h41, 1'b0);
        popOne();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        $display("[TB] ordering and wrap");
        for (int i = 0; i < 20; i++) begin
            sendByte(8'(i), 1'b0);
            if (i % 4 == 3) for (int k = 0; k < 4; k++) popOne();
        end

        $display("[TB] overrun");
        for (int i = 'h10; i <= 'h20; i++) sendByte(8'(i), 1'b0);
        for (int i = 0; i < 16; i++) popOne();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        $display("[TB] push and pop at full");
        for (int i = 0; i < 16; i++) sendByte(8'(8'hA0 + i), 1'b0);
        sendByte(8'h55, 1'b1);
        for (int i = 0; i < 16; i++) popOne();

        $display("[TB] clear coinciding with drop");
        for (int i = 0; i < 16; i++) sendByte(8'(8'hC0 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) popOne();

        $display("[TB] ce gating, held rx_rdy, reset during handshake");
        sendByte(8'h33, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        popOne();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 2) != 0),
                          8'($urandom),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
